// File: rtl/prog_prescaler_pkg.sv
// Shared prescaler constants: reset defaults for the divide stages
// and the chess-clock tick rates built on top of them.
package prog_prescaler_pkg;

   localparam int unsigned PP_DIV_DEFAULT = 4;
   localparam int unsigned PP_SUB_DIV     = 10;

   localparam int unsigned CHESS_TICKS_PER_SEC = 10;
   localparam int unsigned CHESS_SECS_PER_MIN  = 60;
   localparam int unsigned CHESS_TICKS_PER_MIN =
      CHESS_TICKS_PER_SEC * CHESS_SECS_PER_MIN;

endpackage

// File: rtl/modn_counter.sv
// Fixed-modulus enable counter; TC marks the last enabled count
// so stages can be cascaded with zero latency.
module modn_counter
   import prog_prescaler_pkg::*;
#(
   parameter int N = PP_SUB_DIV
)(
   input  logic CLK,
   input  logic CLR,
   input  logic CE,
   input  logic SRST,
   output logic TC
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(N - 1));
   assign TC     = CE & ~SRST & ~CLR & w_last;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_cnt <= '0;
      end else if (SRST) begin
         r_cnt <= '0;
      end else if (CE) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/prog_prescaler.sv
// Two-stage enable prescaler: loadable main divider with shadowed
// factor updates at period boundaries, followed by a fixed sub-divider.
module prog_prescaler
   import prog_prescaler_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DIV_DEFAULT = PP_DIV_DEFAULT,
   parameter int SUB_DIV     = PP_SUB_DIV
)(
   input  logic             CLK,
   input  logic             CLR,
   input  logic             CE,
   input  logic             SRST,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DIV_IN,
   output logic             CEO,
   output logic             CEO_SUB,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] DIV_ACT,
   output logic             PEND
);

   localparam logic [WIDTH-1:0] DEF = WIDTH'(DIV_DEFAULT);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_div_act;
   logic [WIDTH-1:0] r_shadow;
   logic             r_pend;

   logic [WIDTH-1:0] w_din;
   logic [WIDTH-1:0] w_last;
   logic             w_ceo;
   logic             w_apply;
   logic             w_ceo_sub;

   assign w_din   = (DIV_IN == '0) ? WIDTH'(1) : DIV_IN;
   assign w_last  = r_div_act - WIDTH'(1);
   assign w_ceo   = CE & ~SRST & ~CLR & (r_count == w_last);
   assign w_apply = w_ceo | SRST;

   // Factor only changes at an apply, so a period never mixes factors
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_count   <= '0;
         r_div_act <= DEF;
         r_shadow  <= DEF;
         r_pend    <= 1'b0;
      end else if (w_apply) begin
         r_count <= '0;
         r_pend  <= 1'b0;
         if (LOAD) begin
            r_div_act <= w_din;
            r_shadow  <= w_din;
         end else if (r_pend) begin
            r_div_act <= r_shadow;
         end
      end else begin
         if (CE) begin
            r_count <= r_count + WIDTH'(1);
         end
         if (LOAD) begin
            r_shadow <= w_din;
            r_pend   <= 1'b1;
         end
      end
   end

   modn_counter #(
      .N (SUB_DIV)
   ) u_sub (
      .CLK  (CLK),
      .CLR  (CLR),
      .CE   (w_ceo),
      .SRST (SRST),
      .TC   (w_ceo_sub)
   );

   assign CEO     = w_ceo;
   assign CEO_SUB = w_ceo_sub;
   assign COUNT   = r_count;
   assign DIV_ACT = r_div_act;
   assign PEND    = r_pend;

endmodule

// File: tb/tb_prog_prescaler.sv
// Scoreboard bench: stimulus pushes expected outputs from a
// period-remaining reference model; a monitor pops and compares.
module tb_prog_prescaler;

   localparam int W   = 16;
   localparam int DEF = 4;
   localparam int SUB = 10;

   typedef struct packed {
      logic         ceo;
      logic         ceo_sub;
      logic [W-1:0] count;
      logic [W-1:0] div;
      logic         pend;
   } exp_t;

   logic         CLK = 1'b0;
   logic         CLR = 1'b1;
   logic         CE = 1'b0;
   logic         SRST = 1'b0;
   logic         LOAD = 1'b0;
   logic [W-1:0] DIV_IN = '0;
   logic         CEO;
   logic         CEO_SUB;
   logic [W-1:0] COUNT;
   logic [W-1:0] DIV_ACT;
   logic         PEND;

   prog_prescaler #(
      .WIDTH       (W),
      .DIV_DEFAULT (DEF),
      .SUB_DIV     (SUB)
   ) dut (
      .CLK     (CLK),
      .CLR     (CLR),
      .CE      (CE),
      .SRST    (SRST),
      .LOAD    (LOAD),
      .DIV_IN  (DIV_IN),
      .CEO     (CEO),
      .CEO_SUB (CEO_SUB),
      .COUNT   (COUNT),
      .DIV_ACT (DIV_ACT),
      .PEND    (PEND)
   );

   always #5 CLK = ~CLK;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc_no = 0;

   // Model: factor in effect, CEs still needed to end the period,
   // number of main pulses seen modulo SUB, and the waiting factor.
   int m_div, m_rem, m_shadow, m_pulses;
   bit m_pend;

   task automatic m_reset();
      m_div    = DEF;
      m_rem    = DEF;
      m_shadow = DEF;
      m_pend   = 1'b0;
      m_pulses = 0;
   endtask

   task automatic cyc(input bit ce, input bit srst, input bit load,
                      input int din, input bit clr);
      exp_t e;
      bit   ceo;
      int   dinc;
      @(negedge CLK);
      cyc_no++;
      CE     = ce;
      SRST   = srst;
      LOAD   = load;
      DIV_IN = W'(din);
      if (clr) begin
         #1 CLR = 1'b1;
         m_reset();
         e.ceo     = 1'b0;
         e.ceo_sub = 1'b0;
         e.count   = '0;
         e.div     = W'(DEF);
         e.pend    = 1'b0;
         q.push_back(e);
      end else begin
         CLR  = 1'b0;
         ceo  = ce && !srst && (m_rem == 1);
         e.ceo     = ceo;
         e.ceo_sub = ceo && (m_pulses == SUB - 1);
         e.count   = W'(m_div - m_rem);
         e.div     = W'(m_div);
         e.pend    = m_pend;
         q.push_back(e);
         dinc = (din == 0) ? 1 : din;
         if (srst) m_pulses = 0;
         else if (ceo) m_pulses = (m_pulses + 1) % SUB;
         if (ceo || srst) begin
            if (load) m_div = dinc;
            else if (m_pend) m_div = m_shadow;
            m_pend = 1'b0;
            m_rem  = m_div;
         end else begin
            if (ce) m_rem--;
            if (load) begin
               m_shadow = dinc;
               m_pend   = 1'b1;
            end
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(negedge CLK);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {CEO, CEO_SUB, COUNT, DIV_ACT, PEND};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL outputs cycle %0d: got ceo=%b sub=%b cnt=%0d div=%0d pend=%b want ceo=%b sub=%b cnt=%0d div=%0d pend=%b",
                        cyc_no, a.ceo, a.ceo_sub, a.count, a.div, a.pend,
                        e.ceo, e.ceo_sub, e.count, e.div, e.pend);
            end
         end
      end
   end

   initial begin : stim
      int r;
      m_reset();
      cyc(1, 0, 0, 0, 1);
      // CE tied high from reset release
      for (int i = 0; i < 45; i++) cyc(1, 0, 0, 0, 0);
      // CE every third cycle
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 27; i++) cyc(i % 3 == 2, 0, 0, 0, 0);
      // Load 7 at COUNT=1
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 7, 0);
      for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
      // Load 0 then restart: divide by one
      cyc(0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
      // Load with coincident CEO, then overwrite before apply
      cyc(1, 0, 1, 5, 0);
      for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 6, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 9, 0);
      for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0);
      // Clear mid-period with a pending load
      cyc(0, 1, 1, 4, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 11, 0);
      cyc(1, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         cyc($urandom_range(0, 99) < 65, r < 3, $urandom_range(0, 99) < 5,
             $urandom_range(0, 12), r == 50);
      end
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
      #3;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
